peripheral_wb_burst_master: RTL and testbench

Wishbone B3 classic/registered-feedback initiator. It turns a simple command/stream interface into incrementing-burst read or write cycles toward a Wishbone responder such as the single-port RAM slave. It is used by DMA-style engines and by test harnesses to drive memory peripherals. It reports completion, the number of beats completed, and any error (slave err or watchdog timeout).

---
 rtl/peripheral_wb_pkg.sv | 17 +
 rtl/peripheral_wb_watchdog.sv | 33 +++
 rtl/peripheral_wb_burst_master.sv | 196 +++++++++++++++++++
 tb/tb_peripheral_wb_burst_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_wb_pkg.sv
// Shared constants and state encoding for the Wishbone burst initiator.
package peripheral_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_WR_WAIT = 3'd2,
    S_WR_STB  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/peripheral_wb_watchdog.sv
// Stall watchdog: counts consecutive run cycles, flags the last allowed one.
module peripheral_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] LIM =
    CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic ENA = (TIMEOUT != 0);

  logic [CW-1:0] cnt;

  // Fires during the TIMEOUT-th stalled cycle so the abort edge ends it.
  assign expired = ENA & run & (cnt == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && ENA && cnt != LIM) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/peripheral_wb_burst_master.sv
// Wishbone B3 incrementing-burst initiator driven by a command/stream front end.
module peripheral_wb_burst_master
  import peripheral_wb_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16,
  parameter int LW        = $clog2(MAX_BURST),
  parameter int TIMEOUT   = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [LW-1:0]   cmd_len_i,
  input  logic            wdata_valid_i,
  output logic            wdata_ready_o,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wsel_i,
  output logic            rdata_valid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            done_o,
  output logic            done_err_o,
  output logic [LW:0]     done_beats_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic [1:0]      wb_bte_o,
  output logic [2:0]      wb_cti_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int CW = LW + 1;
  localparam logic [AW-1:0] ADR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state;
  logic [LW-1:0] len_r;
  logic [CW-1:0] cnt;
  logic          last;
  logic          next_eob;
  logic          accept;
  logic          stalled;
  logic          expired;
  logic          err_s;
  logic          ack_s;

  assign last     = cnt == {1'b0, len_r};
  assign next_eob = (cnt + CNT_ONE) == {1'b0, len_r};
  assign accept   = (state == S_IDLE) & cmd_valid_i & cmd_ready_o;
  assign stalled  = wb_stb_o & ~wb_ack_i & ~wb_err_i;
  assign err_s    = wb_stb_o & (wb_err_i | expired);
  assign ack_s    = wb_stb_o & wb_ack_i & ~err_s;
  assign wb_bte_o = BTE_LINEAR;

  peripheral_wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .clear  (~stalled),
    .run    (stalled),
    .expired(expired)
  );

  // Only path left unregistered: lets an ack pull the next word same cycle.
  always_comb begin
    wdata_ready_o = 1'b0;
    unique case (1'b1)
      (state == S_WR_WAIT):
        wdata_ready_o = 1'b1;
      (state == S_WR_STB):
        wdata_ready_o = wb_ack_i & ~wb_err_i & ~last;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state         <= S_IDLE;
      len_r         <= '0;
      cnt           <= '0;
      cmd_ready_o   <= 1'b0;
      rdata_valid_o <= 1'b0;
      rdata_o       <= '0;
      done_o        <= 1'b0;
      done_err_o    <= 1'b0;
      done_beats_o  <= '0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
      wb_we_o       <= 1'b0;
      wb_cti_o      <= CTI_CLASSIC;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      done_o        <= 1'b0;
      if (ack_s) begin
        wb_adr_o <= wb_adr_o + ADR_ONE;
        cnt      <= cnt + CNT_ONE;
        wb_cti_o <= next_eob ? CTI_EOB : CTI_INCR;
      end
      if (err_s) begin
        wb_cyc_o     <= 1'b0;
        wb_stb_o     <= 1'b0;
        wb_we_o      <= 1'b0;
        wb_cti_o     <= CTI_CLASSIC;
        done_o       <= 1'b1;
        done_err_o   <= 1'b1;
        done_beats_o <= cnt;
        state        <= S_DONE;
      end else begin
        unique case (state)
          S_IDLE: begin
            cmd_ready_o <= ~accept;
            if (accept) begin
              len_r    <= cmd_len_i;
              cnt      <= '0;
              wb_adr_o <= cmd_adr_i;
              wb_we_o  <= cmd_we_i;
              wb_cyc_o <= 1'b1;
              wb_cti_o <= (cmd_len_i == '0) ? CTI_EOB : CTI_INCR;
              if (cmd_we_i) begin
                state <= S_WR_WAIT;
              end else begin
                wb_stb_o <= 1'b1;
                wb_sel_o <= '1;
                state    <= S_RD;
              end
            end
          end
          S_RD: begin
            if (ack_s) begin
              rdata_valid_o <= 1'b1;
              rdata_o       <= wb_dat_i;
              if (last) begin
                wb_cyc_o     <= 1'b0;
                wb_stb_o     <= 1'b0;
                wb_we_o      <= 1'b0;
                wb_cti_o     <= CTI_CLASSIC;
                done_o       <= 1'b1;
                done_err_o   <= 1'b0;
                done_beats_o <= cnt + CNT_ONE;
                state        <= S_DONE;
              end
            end
          end
          S_WR_WAIT: begin
            if (wdata_valid_i) begin
              wb_dat_o <= wdata_i;
              wb_sel_o <= wsel_i;
              wb_stb_o <= 1'b1;
              state    <= S_WR_STB;
            end
          end
          S_WR_STB: begin
            if (ack_s) begin
              if (last) begin
                wb_cyc_o     <= 1'b0;
                wb_stb_o     <= 1'b0;
                wb_we_o      <= 1'b0;
                wb_cti_o     <= CTI_CLASSIC;
                done_o       <= 1'b1;
                done_err_o   <= 1'b0;
                done_beats_o <= cnt + CNT_ONE;
                state        <= S_DONE;
              end else if (wdata_valid_i) begin
                wb_dat_o <= wdata_i;
                wb_sel_o <= wsel_i;
              end else begin
                wb_stb_o <= 1'b0;
                state    <= S_WR_WAIT;
              end
            end
          end
          S_DONE: begin
            cmd_ready_o  <= 1'b1;
            done_err_o   <= 1'b0;
            done_beats_o <= '0;
            state        <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_peripheral_wb_burst_master.sv
// Directed bench for the Wishbone burst initiator against a small RAM responder.
module tb_peripheral_wb_burst_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 0, cmd_ready_o, cmd_we = 0;
  logic [7:0]  cmd_adr = 0;
  logic [3:0]  cmd_len = 0;
  logic        wdata_valid = 0, wdata_ready_o;
  logic [31:0] wdata = 0;
  logic [3:0]  wsel = 4'hF;
  logic        rdata_valid_o, done_o, done_err_o;
  logic [31:0] rdata_o, wb_dat_o;
  logic [4:0]  done_beats_o;
  logic [7:0]  wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [1:0]  wb_bte_o;
  logic [2:0]  wb_cti_o;
  logic        s_ack = 0, s_err = 0;
  logic [31:0] s_dat = 0;

  peripheral_wb_burst_master #(
    .AW(8), .DW(32), .MAX_BURST(16), .LW(4), .TIMEOUT(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready_o),
    .wdata_i(wdata), .wsel_i(wsel),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o),
    .done_o(done_o), .done_err_o(done_err_o),
    .done_beats_o(done_beats_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_dat_i(s_dat)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Registered-ack RAM responder with error and stall knobs.
  logic [31:0] mem [256];
  int s_beat = 0;
  int err_at = -1;
  bit no_ack = 0;

  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !s_ack && !s_err) begin
      if (no_ack) begin
      end else if (s_beat == err_at) begin
        s_err <= 1'b1;
      end else begin
        s_ack  <= 1'b1;
        s_beat <= s_beat + 1;
        s_dat  <= mem[wb_adr_o];
        if (wb_we_o)
          for (int b = 0; b < 4; b++)
            if (wb_sel_o[b]) mem[wb_adr_o][8*b +: 8] <= wb_dat_o[8*b +: 8];
      end
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
    end
    if (!wb_cyc_o) s_beat <= 0;
  end

  // Write-word source with a configurable idle gap after each word.
  logic [31:0] wq[$];
  int gap = 0, gap_cnt = 0;
  bit hs = 0;

  always @(posedge clk) hs = wdata_valid && wdata_ready_o;

  always @(negedge clk) begin
    if (hs) begin
      void'(wq.pop_front());
      gap_cnt = gap;
      hs = 0;
    end else if (!wdata_valid && gap_cnt > 0) begin
      gap_cnt--;
    end
    wdata_valid = (wq.size() > 0) && (gap_cnt == 0);
    wdata = (wq.size() > 0) ? wq[0] : 32'h0;
  end

  // Bus monitor.
  logic [7:0]  adrq[$];
  logic [2:0]  ctiq[$];
  logic [31:0] rdq[$];
  logic [1:0]  bte_or = 0;
  int stall = 0, drops = 0, dn_cnt = 0;
  bit prev_stb = 0, dn_err = 0, dn_cyc = 0;
  logic [4:0] dn_beats = 0;

  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && s_ack && !s_err) begin
      adrq.push_back(wb_adr_o);
      ctiq.push_back(wb_cti_o);
      bte_or = bte_or | wb_bte_o;
    end
    if (wb_stb_o && !s_ack && !s_err) stall++;
    if (prev_stb && !wb_stb_o && wb_cyc_o) drops++;
    prev_stb = wb_stb_o;
    if (rdata_valid_o) rdq.push_back(rdata_o);
    if (done_o) begin
      dn_cnt++;
      dn_err   = done_err_o;
      dn_beats = done_beats_o;
      dn_cyc   = wb_cyc_o;
    end
  end

  function automatic logic [31:0] pk_adr();
    logic [31:0] p = 0;
    for (int i = 0; i < adrq.size() && i < 4; i++) p = {p[23:0], adrq[i]};
    return p;
  endfunction

  function automatic logic [11:0] pk_cti();
    logic [11:0] p = 0;
    for (int i = 0; i < ctiq.size() && i < 4; i++) p = {p[8:0], ctiq[i]};
    return p;
  endfunction

  task automatic issue(input logic w, input logic [7:0] a,
                       input logic [3:0] l);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_we = w; cmd_adr = a; cmd_len = l;
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 64'(n < 50), 1);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic run_cmd(input logic w, input logic [7:0] a,
                         input logic [3:0] l, input int g);
    int n = 0;
    int seen;
    adrq.delete(); ctiq.delete(); rdq.delete();
    stall = 0; drops = 0; bte_or = 0;
    seen = dn_cnt;
    gap = g;
    issue(w, a, l);
    while (dn_cnt == seen && n < 300) begin
      @(negedge clk);
      #1 n++;
    end
    check("done_seen", 64'(dn_cnt - seen), 1);
  endtask

  initial begin
    int seen, n;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | i;
    mem[8'h05] = 32'h5555_0005;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctl", 64'({cmd_ready_o, rdata_valid_o, done_o, done_err_o,
                          done_beats_o, wb_cyc_o, wb_stb_o, wb_we_o,
                          wb_cti_o, wb_bte_o, wb_adr_o, wdata_ready_o}), 0);
    check("rst_dat", {wb_sel_o, rdata_o}, 0);
    check("rst_wdat", 64'(wb_dat_o), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1 check("idle_ready", 64'(cmd_ready_o), 1);

    // Back-to-back write burst then read back.
    for (int i = 0; i < 4; i++) wq.push_back(32'hCAFE_00A0 + i);
    run_cmd(1, 8'h10, 3, 0);
    check("wr_adrs", pk_adr(), 32'h10111213);
    check("wr_cti", 64'(pk_cti()), 12'b010_010_010_111);
    check("wr_beats", 64'(dn_beats), 4);
    check("wr_err", 64'(dn_err), 0);
    check("wr_b2b_drops", 64'(drops), 0);
    for (int i = 0; i < 4; i++)
      check("wr_mem", 64'(mem[8'h10 + i]), 64'(32'hCAFE_00A0 + i));
    run_cmd(0, 8'h10, 3, 0);
    check("rd_count", 64'(rdq.size()), 4);
    for (int i = 0; i < 4; i++)
      check("rd_data", 64'(rdq[i]), 64'(32'hCAFE_00A0 + i));

    // Single-beat read.
    run_cmd(0, 8'h05, 0, 0);
    check("one_adr", pk_adr(), 32'h05);
    check("one_cti", 64'(pk_cti()), 12'b111);
    check("one_bte", 64'(bte_or), 0);
    check("one_beats", 64'(dn_beats), 1);
    check("one_data", 64'(rdq[0]), 32'h5555_0005);

    // Address wrap.
    run_cmd(0, 8'hFE, 3, 0);
    check("wrap_adrs", pk_adr(), 32'hFEFF0001);
    check("wrap_err", 64'(dn_err), 0);
    check("wrap_beats", 64'(dn_beats), 4);
    check("wrap_d2", 64'(rdq[2]), 32'hDEAD_0000);

    // Write with gaps between words.
    for (int i = 0; i < 4; i++) wq.push_back(32'hBEEF_00B0 + i);
    run_cmd(1, 8'h20, 3, 2);
    check("gap_drops", 64'(drops), 3);
    check("gap_nbeats", 64'(adrq.size()), 4);
    check("gap_beats", 64'(dn_beats), 4);
    for (int i = 0; i < 4; i++)
      check("gap_mem", 64'(mem[8'h20 + i]), 64'(32'hBEEF_00B0 + i));
    gap = 0;

    // Error on the third beat of an 8-beat read.
    err_at = 2;
    run_cmd(0, 8'h40, 7, 0);
    err_at = -1;
    check("err_pulses", 64'(rdq.size()), 2);
    check("err_flag", 64'(dn_err), 1);
    check("err_beats", 64'(dn_beats), 2);
    check("err_cyc", 64'(dn_cyc), 0);
    check("err_d1", 64'(rdq[1]), 32'hDEAD_0041);

    // Watchdog timeout.
    no_ack = 1;
    run_cmd(0, 8'h60, 3, 0);
    check("to_stall", 64'(stall), 8);
    check("to_flag", 64'(dn_err), 1);
    check("to_beats", 64'(dn_beats), 0);
    check("to_cyc", 64'(dn_cyc), 0);

    // Reset in the middle of a stalled burst.
    issue(0, 8'h70, 7);
    n = 0;
    while (!wb_cyc_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rb_started", 64'(wb_cyc_o & wb_stb_o), 1);
    repeat (2) @(negedge clk);
    seen = dn_cnt;
    #2 rst_n = 0;
    #1 check("rb_drop", 64'({wb_cyc_o, wb_stb_o}), 0);
    repeat (3) @(negedge clk);
    no_ack = 0;
    rst_n = 1;
    @(negedge clk);
    #1;
    check("rb_no_done", 64'(dn_cnt - seen), 0);
    check("rb_idle", 64'({cmd_ready_o, wb_cyc_o}), 2'b10);
    run_cmd(0, 8'h05, 0, 0);
    check("rb_after", 64'(rdq[0]), 32'h5555_0005);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
